// File: rtl/seq_fetch_if.sv
// rtl/seq_fetch_if.sv - fetch-stage bus: PC-update/program-load inputs and decoded instruction outputs
interface seq_fetch_if;
  logic        pc_en;
  logic [63:0] new_pc;
  logic        imem_we;
  logic [63:0] imem_waddr;
  logic [7:0]  imem_wdata;
  logic [63:0] pc;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic [63:0] valC;
  logic [63:0] valP;
  logic        instr_valid;
  logic        imem_error;
  logic [2:0]  f_stat;
  logic [2:0]  stat;
  logic        halted;
  logic [63:0] instr_count;

  modport master (
    output pc_en, new_pc, imem_we, imem_waddr, imem_wdata,
    input  pc, icode, ifun, rA, rB, valC, valP, instr_valid, imem_error,
           f_stat, stat, halted, instr_count
  );

  modport slave (
    input  pc_en, new_pc, imem_we, imem_waddr, imem_wdata,
    output pc, icode, ifun, rA, rB, valC, valP, instr_valid, imem_error,
           f_stat, stat, halted, instr_count
  );
endinterface

// File: rtl/seq_fetch.sv
// rtl/seq_fetch.sv - Y86-64 SEQ fetch stage: PC, byte instruction memory, decode split and status
module seq_fetch #(
  parameter int          MEM_BYTES = 1024,
  parameter logic [63:0] RESET_PC  = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  seq_fetch_if.slave  bus
);

  localparam int          AW      = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam logic [64:0] MEM_LIM = 65'(MEM_BYTES);

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_t;

  logic [7:0]  r_mem [MEM_BYTES] = '{default: 8'h00};
  logic [63:0] r_pc;
  stat_t       r_stat;
  logic [63:0] r_count;

  logic [7:0]  w_byte [10];
  logic [3:0]  w_icode;
  logic [3:0]  w_ifun;
  logic        w_need_regids;
  logic        w_need_valc;
  logic [3:0]  w_len;
  logic [63:0] w_valc;
  logic        w_valid;
  logic        w_imem_error;
  stat_t       w_f_stat;
  logic [63:0] w_pc_nxt;
  stat_t       w_stat_nxt;
  logic [63:0] w_count_nxt;

  // Program-load port: memory is never cleared by reset
  always_ff @(posedge clk) begin
    if (bus.imem_we && ({1'b0, bus.imem_waddr} < MEM_LIM)) begin
      r_mem[bus.imem_waddr[AW-1:0]] <= bus.imem_wdata;
    end
  end

  // The longest instruction spans pc..pc+9; bytes past the end of memory read as zero
  for (genvar k = 0; k < 10; k++) begin : g_rd
    logic [64:0] w_addr;
    assign w_addr    = {1'b0, r_pc} + 65'(k);
    assign w_byte[k] = (w_addr < MEM_LIM) ? r_mem[w_addr[AW-1:0]] : 8'h00;
  end

  always_comb begin
    w_icode       = w_byte[0][7:4];
    w_ifun        = w_byte[0][3:0];
    w_need_regids = 1'b0;
    w_need_valc   = 1'b0;
    w_valid       = 1'b0;
    case (w_icode)
      4'h0, 4'h1, 4'h8, 4'h9: w_valid = (w_ifun == 4'h0);
      4'h2: begin w_need_regids = 1'b1; w_valid = (w_ifun <= 4'h6); end
      4'h3, 4'h4, 4'h5: begin
        w_need_regids = 1'b1;
        w_need_valc   = 1'b1;
        w_valid       = (w_ifun == 4'h0);
      end
      4'h6: begin w_need_regids = 1'b1; w_valid = (w_ifun <= 4'h3); end
      4'h7: begin w_need_valc = 1'b1; w_valid = (w_ifun <= 4'h6); end
      4'hA, 4'hB: begin w_need_regids = 1'b1; w_valid = (w_ifun == 4'h0); end
      default: w_valid = 1'b0;
    endcase
    if (w_icode == 4'h8) w_need_valc = 1'b1;

    w_len = 4'd1 + {3'b000, w_need_regids} + (w_need_valc ? 4'd8 : 4'd0);

    if (!w_need_valc)
      w_valc = 64'h0;
    else if (w_need_regids)
      w_valc = {w_byte[9], w_byte[8], w_byte[7], w_byte[6],
                w_byte[5], w_byte[4], w_byte[3], w_byte[2]};
    else
      w_valc = {w_byte[8], w_byte[7], w_byte[6], w_byte[5],
                w_byte[4], w_byte[3], w_byte[2], w_byte[1]};

    // 65-bit so a PC near 2^64 cannot wrap back into range
    w_imem_error = (({1'b0, r_pc} + {61'h0, w_len} - 65'd1) >= MEM_LIM);

    if (w_imem_error)        w_f_stat = STAT_ADR;
    else if (!w_valid)       w_f_stat = STAT_INS;
    else if (w_icode == 4'h0) w_f_stat = STAT_HLT;
    else                     w_f_stat = STAT_AOK;
  end

  always_comb begin
    w_pc_nxt    = r_pc;
    w_stat_nxt  = r_stat;
    w_count_nxt = r_count;
    if (r_stat == STAT_AOK && bus.pc_en) begin
      case (w_f_stat)
        STAT_AOK: begin
          w_pc_nxt    = bus.new_pc;
          w_count_nxt = r_count + 64'd1;
        end
        STAT_HLT: begin
          w_stat_nxt  = STAT_HLT;
          w_count_nxt = r_count + 64'd1;
        end
        default: w_stat_nxt = w_f_stat;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_stat  <= STAT_AOK;
      r_count <= 64'h0;
    end else begin
      r_pc    <= w_pc_nxt;
      r_stat  <= w_stat_nxt;
      r_count <= w_count_nxt;
    end
  end

  assign bus.pc          = r_pc;
  assign bus.icode       = w_icode;
  assign bus.ifun        = w_ifun;
  assign bus.rA          = w_need_regids ? w_byte[1][7:4] : 4'hF;
  assign bus.rB          = w_need_regids ? w_byte[1][3:0] : 4'hF;
  assign bus.valC        = w_valc;
  assign bus.valP        = r_pc + {60'h0, w_len};
  assign bus.instr_valid = w_valid;
  assign bus.imem_error  = w_imem_error;
  assign bus.f_stat      = w_f_stat;
  assign bus.stat        = r_stat;
  assign bus.halted      = (r_stat != STAT_AOK);
  assign bus.instr_count = r_count;

endmodule

// File: tb/tb_seq_fetch.sv
// tb/tb_seq_fetch.sv - directed bench for seq_fetch with a second instance at RESET_PC=1020
module tb_seq_fetch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  seq_fetch_if u_if0 ();
  seq_fetch_if u_if1 ();

  seq_fetch #(.MEM_BYTES(1024), .RESET_PC(64'h0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(u_if0.slave)
  );

  seq_fetch #(.MEM_BYTES(1024), .RESET_PC(64'd1020)) u_dut1 (
    .clk(clk), .rst(rst), .bus(u_if1.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wr(input bit sel, input logic [63:0] addr, input logic [7:0] data);
    if (sel) begin
      u_if1.imem_we = 1'b1; u_if1.imem_waddr = addr; u_if1.imem_wdata = data;
    end else begin
      u_if0.imem_we = 1'b1; u_if0.imem_waddr = addr; u_if0.imem_wdata = data;
    end
    tick();
    u_if0.imem_we = 1'b0;
    u_if1.imem_we = 1'b0;
  endtask

  task automatic step0(input logic [63:0] npc);
    u_if0.pc_en = 1'b1; u_if0.new_pc = npc;
    tick();
    u_if0.pc_en = 1'b0;
  endtask

  initial begin
    logic [7:0] prog [10];
    prog = '{8'h30, 8'hF0, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    u_if0.pc_en = 1'b0; u_if0.new_pc = 64'h0;
    u_if0.imem_we = 1'b0; u_if0.imem_waddr = 64'h0; u_if0.imem_wdata = 8'h00;
    u_if1.pc_en = 1'b0; u_if1.new_pc = 64'h0;
    u_if1.imem_we = 1'b0; u_if1.imem_waddr = 64'h0; u_if1.imem_wdata = 8'h00;

    // Program load happens with rst held high
    for (int i = 0; i < 10; i++) wr(1'b0, 64'(i), prog[i]);
    wr(1'b1, 64'd1020, 8'h30);
    tick();
    rst = 1'b0;

    chk("rst_pc",      u_if0.pc, 64'h0);
    chk("irmovq_icode", 64'(u_if0.icode), 64'h3);
    chk("irmovq_ifun",  64'(u_if0.ifun), 64'h0);
    chk("irmovq_rA",    64'(u_if0.rA), 64'hF);
    chk("irmovq_rB",    64'(u_if0.rB), 64'h0);
    chk("irmovq_valC",  u_if0.valC, 64'h10);
    chk("irmovq_valP",  u_if0.valP, 64'd10);
    chk("rst_f_stat",   64'(u_if0.f_stat), 64'd1);
    chk("rst_stat",     64'(u_if0.stat), 64'd1);
    chk("rst_halted",   64'(u_if0.halted), 64'd0);
    chk("rst_count",    u_if0.instr_count, 64'd0);
    chk("irmovq_valid", 64'(u_if0.instr_valid), 64'd1);
    chk("irmovq_err",   64'(u_if0.imem_error), 64'd0);

    // Instance 1 starts at 1020 with a 10-byte irmovq that runs off the end
    chk("adr_pc",     u_if1.pc, 64'd1020);
    chk("adr_err",    64'(u_if1.imem_error), 64'd1);
    chk("adr_f_stat", 64'(u_if1.f_stat), 64'd3);
    chk("adr_valP",   u_if1.valP, 64'd1030);
    u_if1.pc_en = 1'b1; u_if1.new_pc = 64'd0;
    tick();
    u_if1.pc_en = 1'b0;
    chk("adr_stat",   64'(u_if1.stat), 64'd3);
    chk("adr_halted", 64'(u_if1.halted), 64'd1);
    chk("adr_pc_hold", u_if1.pc, 64'd1020);
    chk("adr_count",  u_if1.instr_count, 64'd0);

    wr(1'b0, 64'd10, 8'h60);
    wr(1'b0, 64'd11, 8'h23);
    wr(1'b0, 64'd12, 8'h00);
    step0(64'd10);
    chk("opq_pc",    u_if0.pc, 64'd10);
    chk("opq_icode", 64'(u_if0.icode), 64'h6);
    chk("opq_rA",    64'(u_if0.rA), 64'h2);
    chk("opq_rB",    64'(u_if0.rB), 64'h3);
    chk("opq_valC",  u_if0.valC, 64'h0);
    chk("opq_valP",  u_if0.valP, 64'd12);
    chk("opq_count", u_if0.instr_count, 64'd1);

    step0(64'd12);
    chk("halt_pc",     u_if0.pc, 64'd12);
    chk("halt_f_stat", 64'(u_if0.f_stat), 64'd2);
    chk("halt_valP",   u_if0.valP, 64'd13);
    chk("halt_rA",     64'(u_if0.rA), 64'hF);
    step0(64'd99);
    chk("halt_stat",   64'(u_if0.stat), 64'd2);
    chk("halt_halted", 64'(u_if0.halted), 64'd1);
    chk("halt_pc2",    u_if0.pc, 64'd12);
    chk("halt_count",  u_if0.instr_count, 64'd3);
    step0(64'd0);
    chk("frozen_pc",    u_if0.pc, 64'd12);
    chk("frozen_count", u_if0.instr_count, 64'd3);
    chk("frozen_stat",  64'(u_if0.stat), 64'd2);

    // Reset beats pc_en, and the same-cycle write still lands
    rst = 1'b1;
    u_if0.pc_en = 1'b1; u_if0.new_pc = 64'd55;
    u_if0.imem_we = 1'b1; u_if0.imem_waddr = 64'd0; u_if0.imem_wdata = 8'h10;
    tick();
    rst = 1'b0; u_if0.pc_en = 1'b0; u_if0.imem_we = 1'b0;
    chk("rst2_pc",    u_if0.pc, 64'd0);
    chk("rst2_stat",  64'(u_if0.stat), 64'd1);
    chk("rst2_count", u_if0.instr_count, 64'd0);
    chk("nop_icode",  64'(u_if0.icode), 64'h1);
    chk("nop_valP",   u_if0.valP, 64'd1);
    chk("nop_f_stat", 64'(u_if0.f_stat), 64'd1);

    wr(1'b0, 64'd1024, 8'h60);
    chk("oob_write_ignored", 64'(u_if0.icode), 64'h1);

    wr(1'b0, 64'd20, 8'h67);
    step0(64'd20);
    chk("ins67_pc",    u_if0.pc, 64'd20);
    chk("ins67_valid", 64'(u_if0.instr_valid), 64'd0);
    chk("ins67_fstat", 64'(u_if0.f_stat), 64'd4);
    step0(64'd0);
    chk("ins_stat",    64'(u_if0.stat), 64'd4);
    chk("ins_pc",      u_if0.pc, 64'd20);
    chk("ins_count",   u_if0.instr_count, 64'd1);

    // While frozen, decode still follows memory at pc
    wr(1'b0, 64'd20, 8'hC0);
    chk("insC0_icode", 64'(u_if0.icode), 64'hC);
    chk("insC0_valid", 64'(u_if0.instr_valid), 64'd0);
    chk("insC0_fstat", 64'(u_if0.f_stat), 64'd4);
    wr(1'b0, 64'd20, 8'h76);
    chk("jxx6_valid", 64'(u_if0.instr_valid), 64'd1);
    chk("jxx6_fstat", 64'(u_if0.f_stat), 64'd1);
    chk("jxx6_valP",  u_if0.valP, 64'd29);
    chk("jxx6_stat",  64'(u_if0.stat), 64'd4);
    step0(64'd0);
    chk("jxx6_pc_hold", u_if0.pc, 64'd20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seq_fetch.md
Name: seq_fetch

Overview:
- Fetch stage of the Y86-64 SEQ processor, sitting directly upstream of `decode`.
- Holds the architectural PC register, a byte-addressed instruction memory, and the processor status register.
- Each cycle it splits the instruction at PC into icode, ifun, rA, rB and valC, and computes valP.
- It advances the PC to the `new_pc` supplied by the PC-update stage, and freezes the machine on halt, invalid instruction or address error.

Parameters:
- MEM_BYTES, 1024, instruction memory size in bytes; valid addresses are 0..MEM_BYTES-1.
- RESET_PC, 64'h0, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- pc_en  input  1  commit the current instruction and load new_pc this cycle.
- new_pc  input  64  next PC from the PC-update stage.
- imem_we  input  1  instruction memory byte write enable (program load).
- imem_waddr  input  64  byte write address.
- imem_wdata  input  8  byte write data.
- pc  output  64  current PC (registered).
- icode  output  4  instruction code.
- ifun  output  4  function code.
- rA  output  4  register A; 4'hF when the instruction has no register byte.
- rB  output  4  register B; 4'hF when the instruction has no register byte.
- valC  output  64  constant word, little-endian; 0 when the instruction has none.
- valP  output  64  address of the next sequential instruction.
- instr_valid  output  1  icode/ifun combination is legal.
- imem_error  output  1  some byte the instruction needs is at or beyond MEM_BYTES.
- f_stat  output  3  combinational status of the current instruction: 1=AOK, 2=HLT, 3=ADR, 4=INS.
- stat  output  3  registered machine status, same encoding.
- halted  output  1  stat != AOK.
- instr_count  output  64  number of committed instructions.

Behaviour:
- Reset (rst=1 at a clk edge): pc<=RESET_PC, stat<=1 (AOK), instr_count<=0, so halted=0.
  - rst has priority over pc_en.
  - Memory contents are NOT cleared; imem_we writes are still performed while rst=1.
- Memory:
  - All bytes are 8'h00 at time zero.
  - A write takes effect at the clk edge; reads are combinational, so a written byte is visible from the following cycle.
  - Writes with imem_waddr >= MEM_BYTES are ignored.
- Instruction fields (all combinational from pc and memory):
  - b0 = mem[pc]; icode = b0[7:4], ifun = b0[3:0].
  - need_regids is set for icode in {2,3,4,5,6,A,B}; rA/rB = mem[pc+1][7:4] / [3:0], otherwise 4'hF.
  - need_valC is set for icode in {3,4,5,7,8}; valC = bytes pc+1+need_regids .. +7, least significant byte first.
  - valP = pc + 1 + need_regids + 8*need_valC, modulo 2^64.
- instr_valid:
  - icode 0, 1, 3, 4, 5, 8, 9, A, B require ifun=0.
  - icode 2 and 7 require ifun 0..6.
  - icode 6 requires ifun 0..3.
  - icode C..F are invalid.
- imem_error:
  - Set when pc >= MEM_BYTES, or pc + len - 1 >= MEM_BYTES, where len is the instruction length.
  - The comparison is evaluated without 64-bit wrap (use 65-bit arithmetic).
  - If the first byte is out of range, the fields read as 0 and only ADR matters.
- f_stat priority: ADR if imem_error, else INS if !instr_valid, else HLT if icode==0, else AOK.
- Clocked update when rst=0, stat==AOK and pc_en=1:
  - f_stat==AOK: pc<=new_pc, instr_count<=instr_count+1.
  - f_stat==HLT: stat<=HLT, instr_count+1, pc unchanged (the halt commits).
  - f_stat==ADR or INS: stat<=f_stat, pc and instr_count unchanged.
- When stat != AOK: pc, stat and instr_count hold until rst, regardless of pc_en; the combinational outputs still track mem[pc].
- When pc_en=0: all registers hold.
- Latency: outputs for a new pc are valid combinationally in the same cycle the pc register updates; one instruction per pc_en cycle.

Test Plan:
- Load bytes 30 F0 10 00 00 00 00 00 00 00 at 0, then pulse rst -> pc=0, icode=3, ifun=0, rA=F, rB=0, valC=64'h10, valP=10, f_stat=1, stat=1, instr_count=0.
- Load 60 23 at 10; from pc=0, pc_en=1 with new_pc=10 -> next cycle pc=10, icode=6, rA=2, rB=3, valP=12, instr_count=1.
- Load 00 at 12; commit to pc=12, then pc_en=1 -> stat=2, halted=1, pc=12, instr_count=3; a further pc_en with new_pc=0 -> no change.
- Byte C0 at pc -> instr_valid=0, f_stat=4; byte 67 -> f_stat=4; on pc_en stat=4, instr_count unchanged, pc held.
- RESET_PC=1020 with MEM_BYTES=1024 and byte 30 at 1020 -> imem_error=1, f_stat=3; on pc_en stat=3.
- From a halted state, assert rst while pc_en=1 and imem_we=1 writes 0x10 at address 0 -> pc=RESET_PC, stat=1, instr_count=0, and mem[0]=10 (icode=1) on the next cycle.
